// File: rtl/multicycle_controller.sv
// Control sequencer for the multi-cycle ARM datapath: main FSM, ALU decoder,
// NZCV flag register and condition check. Optional MemReady handshake under MEM_WAIT_EN.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [3:0]         Cond,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  input  logic [3:0]         Rd,
  input  logic [3:0]         ALUFlags,
`ifdef MEM_WAIT_EN
  input  logic               MemReady,
`endif
  output logic               PCWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic [1:0]         ResultSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         RegSrc,
  output logic [1:0]         ALUControl,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECUTER = STATE_W'(6),
    EXECUTEI = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BRANCH   = STATE_W'(9)
  } state_t;

  state_t     state;
  logic [3:0] flags;
  logic       cond_ex_reg;
  logic       cond_ex;
  logic       mem_ready;
  logic       next_pc, ir_w, mem_w, reg_w, branch, alu_op;
  logic       no_write, pcs;
  logic [1:0] flag_w;

`ifdef MEM_WAIT_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  // ARM condition codes against the registered NZCV flags
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = ~flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = ~flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = ~flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = ~flags[0];
      4'b1000: cond_ex = flags[1] & ~flags[2];
      4'b1001: cond_ex = ~(flags[1] & ~flags[2]);
      4'b1010: cond_ex = (flags[3] == flags[0]);
      4'b1011: cond_ex = (flags[3] != flags[0]);
      4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state       <= FETCH;
      flags       <= '0;
      cond_ex_reg <= 1'b0;
    end else begin
      if (state == DECODE) cond_ex_reg <= cond_ex;
      if (cond_ex_reg && flag_w[1]) flags[3:2] <= ALUFlags[3:2];
      if (cond_ex_reg && flag_w[0]) flags[1:0] <= ALUFlags[1:0];
      case (state)
        FETCH:    if (mem_ready) state <= DECODE;
        DECODE:
          case (Op)
            2'b01:   state <= MEMADR;
            2'b00:   state <= Funct[5] ? EXECUTEI : EXECUTER;
            2'b10:   state <= BRANCH;
            default: state <= FETCH;
          endcase
        MEMADR:   state <= Funct[0] ? MEMREAD : MEMWRITE;
        MEMREAD:  if (mem_ready) state <= MEMWB;
        MEMWRITE: if (mem_ready) state <= FETCH;
        EXECUTER, EXECUTEI: state <= ALUWB;
        default:  state <= FETCH;
      endcase
    end
  end

  always_comb begin
    next_pc   = 1'b0;
    ir_w      = 1'b0;
    mem_w     = 1'b0;
    reg_w     = 1'b0;
    branch    = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    case (state)
      FETCH: begin
        ir_w      = mem_ready;
        next_pc   = mem_ready;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = mem_ready;
      end
      EXECUTER: alu_op = 1'b1;
      EXECUTEI: begin
        alu_op  = 1'b1;
        ALUSrcB = 2'b01;
      end
      ALUWB:    reg_w = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ALUControl = 2'b00;
    if (alu_op) begin
      case (Funct[4:1])
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        4'b1010: ALUControl = 2'b01;
        default: ALUControl = 2'b00;
      endcase
    end
  end

  assign flag_w[1] = alu_op & Funct[0];
  assign flag_w[0] = alu_op & Funct[0] & ~ALUControl[1];
  // CMP is recognised from the held instruction fields, so it still blocks the ALUWB write
  assign no_write  = (Op == 2'b00) && (Funct[4:1] == 4'b1010);
  assign pcs       = ((Rd == 4'd15) & reg_w) | branch;

  assign PCWrite  = ~Reset & (next_pc | (pcs & cond_ex_reg));
  assign RegWrite = ~Reset & reg_w & cond_ex_reg & ~no_write;
  assign MemWrite = ~Reset & mem_w & cond_ex_reg;
  assign IRWrite  = ~Reset & ir_w;
  assign ImmSrc   = Op;
  assign RegSrc   = {Op == 2'b01, Op == 2'b10};
  assign State    = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction expected cycle plans
// built from the instruction rules, directed cases plus randomized instruction stream.
module tb_multicycle_controller;

`ifdef MEM_WAIT_EN
  localparam int MAXW = 2;
`else
  localparam int MAXW = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       Reset = 1'b1;
  logic [3:0] Cond = 4'hE;
  logic [1:0] Op = 2'b11;
  logic [5:0] Funct = '0;
  logic [3:0] Rd = '0;
  logic [3:0] ALUFlags = '0;
  logic       MemReady = 1'b1;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
  logic [3:0] State;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .Reset(Reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags),
`ifdef MEM_WAIT_EN
    .MemReady(MemReady),
`endif
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .State(State)
  );

  typedef struct {
    logic       rst;
    logic       mr;
    int         st;
    logic       pcw, mw, rw, irw, adr, asa;
    logic [1:0] rs, asb, alc;
  } row_t;

  row_t        cur;
  logic        cur_valid = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [3:0]  m_flags = '0;
  logic [31:0] seq_packed = '0;
  int          seq_len = 0;
  int          mw_count = 0;
  logic        last_pcw = 1'b0;
  logic        last_rw = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_dec(input logic [3:0] f4);
    if (f4 == 4'b0010 || f4 == 4'b1010) return 2'b01;
    if (f4 == 4'b0000) return 2'b10;
    if (f4 == 4'b1100) return 2'b11;
    return 2'b00;
  endfunction

  function automatic row_t r0(input int st);
    row_t r;
    r.rst = 1'b0; r.mr = 1'($urandom); r.st = st;
    r.pcw = 0; r.mw = 0; r.rw = 0; r.irw = 0; r.adr = 0; r.asa = 0;
    r.rs = 2'b00; r.asb = 2'b00; r.alc = 2'b00;
    return r;
  endfunction

  function automatic row_t fetch_row(input logic ready);
    row_t r;
    r = r0(0);
    r.mr = ready; r.irw = ready; r.pcw = ready;
    r.asa = 1'b1; r.asb = 2'b10; r.rs = 2'b10;
    return r;
  endfunction

  function automatic int pick_wait(input int waits);
    return (waits < 0) ? int'($urandom_range(0, MAXW)) : 0;
  endfunction

  always @(negedge clk) begin
    if (cur_valid) begin
      chk("State", State, cur.st);
      chk("PCWrite", PCWrite, cur.pcw);
      chk("MemWrite", MemWrite, cur.mw);
      chk("RegWrite", RegWrite, cur.rw);
      chk("IRWrite", IRWrite, cur.irw);
      chk("AdrSrc", AdrSrc, cur.adr);
      chk("ResultSrc", ResultSrc, cur.rs);
      chk("ALUSrcA", ALUSrcA, cur.asa);
      chk("ALUSrcB", ALUSrcB, cur.asb);
      chk("ALUControl", ALUControl, cur.alc);
      chk("ImmSrc", ImmSrc, Op);
      chk("RegSrc", RegSrc, {Op == 2'b01, Op == 2'b10});
      seq_packed = {seq_packed[27:0], State};
      seq_len++;
      if (MemWrite) mw_count++;
      last_pcw = PCWrite;
      last_rw  = RegWrite;
    end
  end

  task automatic do_reset(input int n);
    row_t r;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      r = fetch_row(1'b0);
      r.rst = 1'b1;
      Reset = 1'b1; MemReady = r.mr; cur = r; cur_valid = 1'b1;
    end
    m_flags = '0;
  endtask

  task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                           input logic [3:0] rd, input logic [3:0] af, input int waits,
                           input int abort_after);
    row_t plan[$];
    row_t r;
    logic ok;
    int   w;
    ok = cond_check(c, m_flags);
    w = (waits < 0) ? int'($urandom_range(0, MAXW)) : waits;
    repeat (w) plan.push_back(fetch_row(1'b0));
    plan.push_back(fetch_row(1'b1));
    r = r0(1); r.asa = 1; r.asb = 2'b10; r.rs = 2'b10; plan.push_back(r);
    case (op)
      2'b01: begin
        r = r0(2); r.asb = 2'b01; plan.push_back(r);
        w = pick_wait(waits);
        if (fn[0]) begin
          repeat (w) begin r = r0(3); r.adr = 1; r.mr = 0; plan.push_back(r); end
          r = r0(3); r.adr = 1; r.mr = 1; plan.push_back(r);
          r = r0(4); r.rs = 2'b01; r.rw = ok; r.pcw = ok && (rd == 4'd15); plan.push_back(r);
        end else begin
          repeat (w) begin r = r0(5); r.adr = 1; r.mr = 0; plan.push_back(r); end
          r = r0(5); r.adr = 1; r.mr = 1; r.mw = ok; plan.push_back(r);
        end
      end
      2'b00: begin
        r = r0(fn[5] ? 7 : 6); r.asb = fn[5] ? 2'b01 : 2'b00; r.alc = alu_dec(fn[4:1]);
        plan.push_back(r);
        r = r0(8); r.rw = ok && (fn[4:1] != 4'b1010); r.pcw = ok && (rd == 4'd15);
        plan.push_back(r);
      end
      2'b10: begin
        r = r0(9); r.asb = 2'b01; r.rs = 2'b10; r.pcw = ok; plan.push_back(r);
      end
      default: ;
    endcase
    for (int i = 0; i < plan.size(); i++) begin
      if (abort_after == 0 || i < abort_after) begin
        @(posedge clk); #1;
        if (i == 0) begin
          Cond = c; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
          seq_packed = '0; seq_len = 0; mw_count = 0;
        end
        Reset = plan[i].rst; MemReady = plan[i].mr; cur = plan[i]; cur_valid = 1'b1;
      end
    end
    @(negedge clk); #1;
    if (abort_after == 0 && op == 2'b00 && ok && fn[0]) begin
      m_flags[3:2] = af[3:2];
      if (alu_dec(fn[4:1]) inside {2'b00, 2'b01}) m_flags[1:0] = af[1:0];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] c;
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] f4tab [5];
    f4tab[0] = 4'b0100; f4tab[1] = 4'b0010; f4tab[2] = 4'b0000;
    f4tab[3] = 4'b1100; f4tab[4] = 4'b1010;

    do_reset(2);
    run_instr(4'hE, 2'b01, 6'b011001, 4'd3, 4'h0, 0, 0);
    chk("ldr_seq_len", seq_len, 5);
    chk("ldr_seq", seq_packed[19:0], 20'h01234);
    run_instr(4'hE, 2'b01, 6'b011000, 4'd3, 4'h0, 0, 0);
    chk("str_seq", seq_packed[15:0], 16'h0125);
    chk("str_memwrite_cycles", mw_count, 1);
    run_instr(4'hE, 2'b00, 6'b000101, 4'd1, 4'b0100, 0, 0);
    chk("model_flags_subs", m_flags, 4'b0100);
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, 0, 0);
    chk("beq_seq", seq_packed[11:0], 12'h019);
    chk("beq_taken_pcwrite", last_pcw, 1);
    run_instr(4'hE, 2'b00, 6'b000101, 4'd1, 4'b0000, 0, 0);
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, 0, 0);
    chk("beq_not_taken_pcwrite", last_pcw, 0);
    run_instr(4'hE, 2'b00, 6'b000101, 4'd1, 4'b0100, 0, 0);
    run_instr(4'h1, 2'b00, 6'b001000, 4'd2, 4'h0, 0, 0);
    chk("addne_z1_regwrite", last_rw, 0);
    run_instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b1001, 0, 0);
    chk("cmp_regwrite", last_rw, 0);
    chk("model_flags_cmp", m_flags, 4'b1001);
    run_instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'h0, 0, 0);
    chk("nop_seq_len", seq_len, 2);
    // flags set Z=1, then reset mid-LDR must clear them
    run_instr(4'hE, 2'b00, 6'b000101, 4'd1, 4'b0100, 0, 0);
    run_instr(4'hE, 2'b01, 6'b011001, 4'd3, 4'h0, 0, 3);
    do_reset(2);
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, 0, 0);
    chk("beq_after_reset_pcwrite", last_pcw, 0);
`ifdef MEM_WAIT_EN
    run_instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'h0, 3, 0);
    chk("wait_fetch_seq_len", seq_len, 5);
    chk("wait_fetch_seq", seq_packed[19:0], 20'h00001);
`endif

    for (int k = 0; k < 300; k++) begin
      op = 2'($urandom_range(0, 3));
      c  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hE;
      fn = 6'($urandom);
      if (op == 2'b00 && $urandom_range(0, 4) != 0) fn[4:1] = f4tab[$urandom_range(0, 4)];
      run_instr(c, op, fn, 4'($urandom), 4'($urandom), -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
